// File: rtl/riscv_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pipe_pkg
// Brief    : Shared pipeline types and constants for the instruction fetch
//            sequencer (fetch FSM encoding, reset PC, PC step, NOP).
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pipe_pkg;

   // Fetch sequencer state encoding
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,   // issue a request for current_pc
      S_WAIT = 2'd1,   // request granted, waiting for the response
      S_HOLD = 2'd2    // response captured while ID was stalled
   } fetch_state_e;

   localparam logic [9:0]  PC_RESET = 10'h000;
   localparam int unsigned PC_STEP  = 4;
   localparam int unsigned INSTR_W  = 32;
   localparam logic [31:0] NOP      = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/fetch_hold_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_hold_buffer
// Brief    : Single-entry instruction/PC register that parks a fetched
//            instruction while the ID stage is stalled. Clear wins over load.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_hold_buffer #(
   parameter int unsigned AW = 10,
   parameter int unsigned IW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_i,
   input  logic          clear_i,
   input  logic [IW-1:0] instr_i,
   input  logic [AW-1:0] pc_i,
   output logic [IW-1:0] instr_o,
   output logic [AW-1:0] pc_o
);

   logic [IW-1:0] instr_q;
   logic [AW-1:0] pc_q;

   // Capture on load, drop contents on clear (a redirect or release)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr_q <= '0;
         pc_q    <= '0;
      end else if (clear_i) begin
         instr_q <= '0;
         pc_q    <= '0;
      end else if (load_i) begin
         instr_q <= instr_i;
         pc_q    <= pc_i;
      end
   end

   assign instr_o = instr_q;
   assign pc_o    = pc_q;

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : Instruction-fetch controller. Steps the external PC register,
//            runs a one-outstanding req/gnt/rvalid handshake to instruction
//            memory and feeds the IF/ID register, honouring ID stalls and
//            EX redirects (stale in-flight fetches are discarded).
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
   parameter int unsigned AW      = 10,
   parameter int unsigned IW      = riscv_pipe_pkg::INSTR_W,
   parameter int unsigned PC_STEP = riscv_pipe_pkg::PC_STEP
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] current_pc,
   output logic          pc_write,
   output logic [AW-1:0] next_pc,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_gnt,
   input  logic          imem_rvalid,
   input  logic [IW-1:0] imem_rdata,
   input  logic          id_stall,
   input  logic          redirect_valid,
   input  logic [AW-1:0] redirect_pc,
   output logic          ifid_valid,
   output logic [IW-1:0] ifid_instr,
   output logic [AW-1:0] ifid_pc
);
   import riscv_pipe_pkg::*;

   localparam logic [AW-1:0] c_pc_step = AW'(PC_STEP);
   localparam logic [AW-1:0] c_align   = AW'(3);
   localparam logic [AW-1:0] c_pc_rst  = AW'(PC_RESET);

   fetch_state_e  state_q, state_d;
   logic          stale_q, stale_d;
   logic [AW-1:0] req_pc_q, req_pc_d;
   logic          ifid_valid_q, ifid_valid_d;
   logic [IW-1:0] ifid_instr_q, ifid_instr_d;
   logic [AW-1:0] ifid_pc_q, ifid_pc_d;

   logic          w_ifid_blocked;
   logic          w_grant;
   logic          w_hold_load;
   logic          w_hold_clear;
   logic [IW-1:0] w_hold_instr;
   logic [AW-1:0] w_hold_pc;

   // An occupied IF/ID that ID refuses blocks both new requests and direct loads
   assign w_ifid_blocked = ifid_valid_q && id_stall;
   assign imem_req  = !reset && (state_q == S_REQ) && !redirect_valid && !w_ifid_blocked;
   assign w_grant   = imem_req && imem_gnt;
   assign imem_addr = current_pc;
   // The PC register only moves on a grant (sequential step) or a redirect
   assign pc_write  = !reset && (redirect_valid || w_grant);
   assign next_pc   = redirect_valid ? (redirect_pc & ~c_align) : (current_pc + c_pc_step);

   fetch_hold_buffer #(
      .AW (AW),
      .IW (IW)
   ) u_hold (
      .clk     (clk),
      .reset   (reset),
      .load_i  (w_hold_load),
      .clear_i (w_hold_clear),
      .instr_i (imem_rdata),
      .pc_i    (req_pc_q),
      .instr_o (w_hold_instr),
      .pc_o    (w_hold_pc)
   );

   // Next-state and IF/ID update; redirect overrides everything else
   always_comb begin
      state_d      = state_q;
      stale_d      = stale_q;
      req_pc_d     = req_pc_q;
      ifid_valid_d = ifid_valid_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc_d    = ifid_pc_q;
      w_hold_load  = 1'b0;
      w_hold_clear = 1'b0;

      // ID consumed the current instruction; a load below may refill it
      if (ifid_valid_q && !id_stall) begin
         ifid_valid_d = 1'b0;
      end

      if (redirect_valid) begin
         ifid_valid_d = 1'b0;
         case (state_q)
            S_WAIT: begin
               if (imem_rvalid) begin
                  stale_d = 1'b0;
                  state_d = S_REQ;
               end else begin
                  stale_d = 1'b1;
               end
            end
            S_HOLD: begin
               w_hold_clear = 1'b1;
               state_d      = S_REQ;
            end
            default: state_d = S_REQ;
         endcase
      end else begin
         case (state_q)
            S_REQ: begin
               if (w_grant) begin
                  req_pc_d = current_pc;
                  state_d  = S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  if (stale_q) begin
                     stale_d = 1'b0;
                     state_d = S_REQ;
                  end else if (!w_ifid_blocked) begin
                     ifid_valid_d = 1'b1;
                     ifid_instr_d = imem_rdata;
                     ifid_pc_d    = req_pc_q;
                     state_d      = S_REQ;
                  end else begin
                     w_hold_load = 1'b1;
                     state_d     = S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (!id_stall) begin
                  ifid_valid_d = 1'b1;
                  ifid_instr_d = w_hold_instr;
                  ifid_pc_d    = w_hold_pc;
                  w_hold_clear = 1'b1;
                  state_d      = S_REQ;
               end
            end
            default: state_d = S_REQ;
         endcase
      end
   end

   // State, in-flight bookkeeping and IF/ID registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_REQ;
         stale_q      <= 1'b0;
         req_pc_q     <= c_pc_rst;
         ifid_valid_q <= 1'b0;
         ifid_instr_q <= '0;
         ifid_pc_q    <= c_pc_rst;
      end else begin
         state_q      <= state_d;
         stale_q      <= stale_d;
         req_pc_q     <= req_pc_d;
         ifid_valid_q <= ifid_valid_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc_q    <= ifid_pc_d;
      end
   end

   assign ifid_valid = ifid_valid_q;
   assign ifid_instr = ifid_instr_q;
   assign ifid_pc    = ifid_pc_q;

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller that sequences the 10-bit program counter register.
- Drives that register's PCWrite/next_pc inputs and reads back current_pc.
- Runs a one-outstanding request/grant/response handshake to instruction memory and presents fetched instructions to the IF/ID boundary.
- Handles the ID-stage stall and EX-stage branch/jump redirects, discarding any stale in-flight fetch.

Parameters:
- AW, 10, instruction address width (byte address).
- IW, 32, instruction width.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- current_pc  in  AW  value held by the program counter register.
- pc_write  out  1  PCWrite strobe to the PC register.
- next_pc  out  AW  next PC value to the PC register.
- imem_req  out  1  fetch request.
- imem_addr  out  AW  fetch address (= current_pc).
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response valid; exactly one per grant, latency ≥1 cycle.
- imem_rdata  in  IW  response instruction.
- id_stall  in  1  ID stage cannot accept a new instruction.
- redirect_valid  in  1  taken branch/jump from EX, single-cycle pulse.
- redirect_pc  in  AW  redirect target.
- ifid_valid  out  1  IF/ID instruction valid (registered).
- ifid_instr  out  IW  IF/ID instruction (registered).
- ifid_pc  out  AW  PC of ifid_instr (registered).

Behaviour:
- States: S_REQ (issue request), S_WAIT (request granted, awaiting response), S_HOLD (response captured, ID stalled).
- Internal registers: req_pc (PC of the in-flight fetch), stale flag, hold_instr/hold_pc.
- Reset (async): state=S_REQ, stale=0, ifid_valid=0, ifid_instr=0, ifid_pc=0, req_pc=0, hold regs=0.
- Reset outputs: pc_write=0, imem_req=0 while reset is asserted. next_pc and imem_addr are combinational; next_pc defaults to current_pc+PC_STEP.
- imem_req = (state==S_REQ) && !redirect_valid && !(ifid_valid && id_stall).
- imem_addr = current_pc.
- Grant in S_REQ (imem_req && imem_gnt):
  - pc_write=1, next_pc=current_pc+PC_STEP (mod 2^AW; 0x3FC wraps to 0x000).
  - req_pc<=current_pc; go to S_WAIT.
  - Grant without req is ignored.
- S_WAIT, imem_rvalid, stale=0:
  - If !(ifid_valid && id_stall): ifid<= {1, imem_rdata, req_pc}; go to S_REQ.
  - Else capture into hold regs; go to S_HOLD.
- S_WAIT, imem_rvalid, stale=1: discard response, clear stale, go to S_REQ. ifid is not updated.
- S_HOLD: when !id_stall, ifid<= {1, hold_instr, hold_pc}; go to S_REQ.
- IF/ID consumption: when ifid_valid && !id_stall and no new instruction is loaded that cycle, ifid_valid<=0. ifid regs hold value while id_stall=1.
- Redirect has highest priority, in any state:
  - pc_write=1, next_pc = redirect_pc with bits[1:0] forced to 0.
  - ifid_valid<=0 next cycle, regardless of id_stall.
  - S_REQ: no request that cycle; stay S_REQ.
  - S_WAIT without same-cycle rvalid: stale<=1; stay S_WAIT.
  - S_WAIT with same-cycle rvalid: drop response, stale<=0, go to S_REQ.
  - S_HOLD: drop hold contents, go to S_REQ.
- Throughput: at most one outstanding fetch; best case 1 instruction per 2 cycles with 1-cycle memory latency.
- pc_write is asserted only on grant or redirect; never in any other cycle.
- Reset mid-transaction: state returns to S_REQ immediately; any later rvalid arriving in S_REQ is ignored.

Decomposition:
- Package riscv_pipe_pkg:
  - Fetch state encoding (S_REQ=2'd0, S_WAIT=2'd1, S_HOLD=2'd2).
  - PC_RESET=10'h000, PC_STEP=4, instruction width, NOP=32'h00000013 (used by the bench for fill).
- One sub-module: fetch_hold_buffer, a single-entry instr/pc register with load/clear, used for the S_HOLD capture.
- FSM, PC arithmetic and IF/ID registers stay in fetch_sequencer.

Test Plan:
- Sequential fetch, 1-cycle latency, gnt=1, no stall, current_pc from 0x000 → requests at 0x000, 0x004, 0x008; ifid_pc follows 0x000, 0x004, 0x008; pc_write pulses once per grant.
- Wrap: current_pc=0x3FC granted → next_pc=0x000; ifid_pc=0x3FC.
- Stall: id_stall=1 while ifid_valid=1 and a response arrives → ifid holds old instruction, FSM in S_HOLD, imem_req=0. Releasing the stall → held instruction appears next cycle.
- Redirect in S_WAIT to 0x123 → next_pc=0x120, pc_write=1, ifid_valid=0. Late rvalid (data 0xDEADBEEF) is discarded; next request is to address 0x120.
- Redirect and rvalid in the same cycle → response dropped, S_REQ next, no ifid_valid.
- Assert reset while in S_WAIT → all outputs return to reset values asynchronously; after release the first request is issued to current_pc=0x000.
